// File: rtl/fault_seq_pkg.sv
// Shared constants for the fault reset sequencer: state codes, amplitude and fault-count sizing.
package fault_seq_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_RUN        = 3'd0;
   localparam logic [STATE_W-1:0] ST_RAMP_DOWN  = 3'd1;
   localparam logic [STATE_W-1:0] ST_HOLD_RESET = 3'd2;
   localparam logic [STATE_W-1:0] ST_RECOVER    = 3'd3;
   localparam logic [STATE_W-1:0] ST_RAMP_UP    = 3'd4;
   localparam logic [STATE_W-1:0] ST_LOCKOUT    = 3'd5;

   localparam int unsigned FC_W      = 4;
   localparam int unsigned AMP_W_DEF = 8;

   // Full-scale amplitude for a given gain width.
   function automatic int unsigned amp_full(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

   localparam int unsigned AMP_FULL = amp_full(AMP_W_DEF);

endpackage

// File: rtl/amp_ramp.sv
// Registered amplitude ramp: moves toward target by STEP per cycle, clamping at target.
module amp_ramp #(
   parameter int unsigned AMP_W = 8,
   parameter int unsigned STEP  = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [AMP_W-1:0] target,
   output logic [AMP_W-1:0] amp,
   output logic             done_c
);

   localparam int unsigned EXT_W = AMP_W + 1;

   logic [EXT_W-1:0] up_sum;
   logic [EXT_W-1:0] dn_diff;
   logic [EXT_W-1:0] tgt_ext;
   logic [AMP_W-1:0] amp_nxt;

   // Next amplitude; one extra bit exposes overflow/underflow before the clamp.
   always_comb begin
      tgt_ext = {1'b0, target};
      up_sum  = {1'b0, amp} + EXT_W'(STEP);
      dn_diff = {1'b0, amp} - EXT_W'(STEP);
      amp_nxt = amp;
      if (amp < target) begin
         amp_nxt = (up_sum >= tgt_ext) ? target : up_sum[AMP_W-1:0];
      end else if (amp > target) begin
         amp_nxt = (dn_diff[AMP_W] || (dn_diff <= tgt_ext)) ? target : dn_diff[AMP_W-1:0];
      end
      done_c = (amp_nxt == target);
   end

   // Amplitude register, starts silent.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         amp <= '0;
      end else begin
         amp <= amp_nxt;
      end
   end

endmodule

// File: rtl/fault_reset_sequencer.sv
// Ordered recovery of the AM transmit path on watchdog faults, with fault counting and lockout.
// Optional build macro FAULT_TIMESTAMP_EN adds first/last fault cycle timestamps.
module fault_reset_sequencer
   import fault_seq_pkg::*;
#(
   parameter int unsigned AMP_W          = AMP_W_DEF,
   parameter int unsigned RAMP_STEP      = 4,
   parameter int unsigned WARN_LEVEL     = 128,
   parameter int unsigned RESET_CYCLES   = 16,
   parameter int unsigned RECOVER_CYCLES = 64,
   parameter int unsigned MAX_FAULTS     = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             force_reset,
   input  logic             warning,
   input  logic             clear_lockout,
   output logic [AMP_W-1:0] amp_scale,
   output logic             rf_mute,
   output logic             sys_rstn,
   output logic             busy,
   output logic             lockout,
   output logic [FC_W-1:0]  fault_count
`ifdef FAULT_TIMESTAMP_EN
   ,
   output logic [31:0]      last_fault_time,
   output logic [31:0]      first_fault_time
`endif
);

   localparam int unsigned CNT_MAX = (RESET_CYCLES > RECOVER_CYCLES) ? RESET_CYCLES : RECOVER_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [AMP_W-1:0] AMP_TOP  = AMP_W'(amp_full(AMP_W));
   localparam logic [AMP_W-1:0] AMP_WARN = AMP_W'(WARN_LEVEL);
   localparam logic [FC_W-1:0]  FC_SAT   = '1;

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [FC_W-1:0]    fc_nxt;
   logic [FC_W-1:0]    fc_inc;
   logic               mute_nxt;
   logic               srst_nxt;
   logic               busy_nxt;
   logic               lock_nxt;
   logic [AMP_W-1:0]   target;
   logic               ramp_done;

   amp_ramp #(
      .AMP_W (AMP_W),
      .STEP  (RAMP_STEP)
   ) u_amp_ramp (
      .clk    (clk),
      .rstn   (rstn),
      .target (target),
      .amp    (amp_scale),
      .done_c (ramp_done)
   );

   // Ramp target: carrier level in RUN/RAMP_UP unless a fault is being taken, otherwise silence.
   always_comb begin
      target = '0;
      if (((state == ST_RUN) || (state == ST_RAMP_UP)) && !force_reset) begin
         target = warning ? AMP_WARN : AMP_TOP;
      end
   end

   // Next state, shared down-counter, fault count and registered output values.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fc_nxt    = fault_count;
      mute_nxt  = rf_mute;
      srst_nxt  = 1'b1;
      fc_inc    = (fault_count == FC_SAT) ? fault_count : fault_count + FC_W'(1);

      case (state)
         ST_RUN, ST_RAMP_UP: begin
            mute_nxt = 1'b0;
            if (force_reset) begin
               fc_nxt    = fc_inc;
               state_nxt = (fc_inc >= FC_W'(MAX_FAULTS)) ? ST_LOCKOUT : ST_RAMP_DOWN;
            end else if ((state == ST_RAMP_UP) && ramp_done) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RAMP_DOWN: begin
            if (ramp_done) begin
               mute_nxt  = 1'b1;
               srst_nxt  = 1'b0;
               cnt_nxt   = CNT_W'(RESET_CYCLES - 1);
               state_nxt = ST_HOLD_RESET;
            end
         end
         ST_HOLD_RESET: begin
            mute_nxt = 1'b1;
            if (cnt == '0) begin
               cnt_nxt   = CNT_W'(RECOVER_CYCLES - 1);
               state_nxt = ST_RECOVER;
            end else begin
               srst_nxt = 1'b0;
               cnt_nxt  = cnt - CNT_W'(1);
            end
         end
         ST_RECOVER: begin
            mute_nxt = 1'b1;
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else if (!force_reset) begin
               mute_nxt  = 1'b0;
               state_nxt = ST_RAMP_UP;
            end
         end
         ST_LOCKOUT: begin
            if (clear_lockout) begin
               fc_nxt    = '0;
               mute_nxt  = 1'b1;
               srst_nxt  = 1'b0;
               cnt_nxt   = CNT_W'(RESET_CYCLES - 1);
               state_nxt = ST_HOLD_RESET;
            end else begin
               mute_nxt = rf_mute | ramp_done;
            end
         end
         default: begin
            state_nxt = ST_RAMP_UP;
         end
      endcase

      busy_nxt = (state_nxt != ST_RUN);
      lock_nxt = (state_nxt == ST_LOCKOUT);
   end

   // State and output registers; reset parks in RAMP_UP with RF muted and downstream held in reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_RAMP_UP;
         cnt         <= '0;
         fault_count <= '0;
         rf_mute     <= 1'b1;
         sys_rstn    <= 1'b0;
         busy        <= 1'b1;
         lockout     <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         fault_count <= fc_nxt;
         rf_mute     <= mute_nxt;
         sys_rstn    <= srst_nxt;
         busy        <= busy_nxt;
         lockout     <= lock_nxt;
      end
   end

`ifdef FAULT_TIMESTAMP_EN
   logic [31:0] cycle_cnt;
   logic        fault_taken;
   logic        clear_taken;

   assign fault_taken = ((state == ST_RUN) || (state == ST_RAMP_UP)) && force_reset;
   assign clear_taken = (state == ST_LOCKOUT) && clear_lockout;

   // Free-running cycle counter and fault timestamp capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_cnt        <= '0;
         last_fault_time  <= '0;
         first_fault_time <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (clear_taken) begin
            last_fault_time  <= '0;
            first_fault_time <= '0;
         end else if (fault_taken) begin
            last_fault_time <= cycle_cnt;
            if (fault_count == '0) begin
               first_fault_time <= cycle_cnt;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_fault_reset_sequencer.sv
// Scoreboard bench for fault_reset_sequencer: stimulus queues cycle-tagged expectations, a monitor checks them.
module tb_fault_reset_sequencer;

   localparam int S_AMP   = 0;
   localparam int S_MUTE  = 1;
   localparam int S_SRST  = 2;
   localparam int S_BUSY  = 3;
   localparam int S_LOCK  = 4;
   localparam int S_FC    = 5;
   localparam int S_LAST  = 6;
   localparam int S_FIRST = 7;

   typedef struct {
      int          cyc;
      int          sig;
      int unsigned val;
      string       name;
   } chk_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       force_reset = 1'b0;
   logic       warning = 1'b0;
   logic       clear_lockout = 1'b0;
   logic [7:0] amp_scale;
   logic       rf_mute;
   logic       sys_rstn;
   logic       busy;
   logic       lockout;
   logic [3:0] fault_count;
`ifdef FAULT_TIMESTAMP_EN
   logic [31:0] last_fault_time;
   logic [31:0] first_fault_time;
`endif

   chk_t        sb[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] got;

   fault_reset_sequencer dut (
      .clk           (clk),
      .rstn          (rstn),
      .force_reset   (force_reset),
      .warning       (warning),
      .clear_lockout (clear_lockout),
      .amp_scale     (amp_scale),
      .rf_mute       (rf_mute),
      .sys_rstn      (sys_rstn),
      .busy          (busy),
      .lockout       (lockout),
      .fault_count   (fault_count)
`ifdef FAULT_TIMESTAMP_EN
      ,
      .last_fault_time  (last_fault_time),
      .first_fault_time (first_fault_time)
`endif
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] get_sig(input int s);
      case (s)
         S_AMP:   return 32'(amp_scale);
         S_MUTE:  return 32'(rf_mute);
         S_SRST:  return 32'(sys_rstn);
         S_BUSY:  return 32'(busy);
         S_LOCK:  return 32'(lockout);
         S_FC:    return 32'(fault_count);
`ifdef FAULT_TIMESTAMP_EN
         S_LAST:  return last_fault_time;
         S_FIRST: return first_fault_time;
`endif
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: compare every expectation due in this cycle, away from the active edge.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            n_checks = n_checks + 1;
            got = get_sig(sb[i].sig);
            if (got !== 32'(sb[i].val)) begin
               n_fail = n_fail + 1;
               $display("FAIL %s cyc=%0d got=%0d expected=%0d", sb[i].name, cyc, got, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic expect_at(input int d, input int s, input int unsigned v, input string nm);
      chk_t c;
      c.cyc  = cyc + d;
      c.sig  = s;
      c.val  = v;
      c.name = nm;
      sb.push_back(c);
   endtask

   initial begin
      repeat (5000) @(posedge clk);
      $display("FAIL watchdog cycle budget expired cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset values, then ramp 0 -> 255 in 64 cycles
      tick(2);
      expect_at(0, S_AMP, 0, "rst_amp");
      expect_at(0, S_MUTE, 1, "rst_mute");
      expect_at(0, S_SRST, 0, "rst_srst");
      expect_at(0, S_BUSY, 1, "rst_busy");
      expect_at(0, S_LOCK, 0, "rst_lock");
      expect_at(0, S_FC, 0, "rst_fc");
      rstn = 1'b1;
      expect_at(0, S_SRST, 0, "t1_srst_low");
      expect_at(1, S_SRST, 1, "t1_srst_high");
      expect_at(1, S_MUTE, 0, "t1_unmute");
      expect_at(1, S_AMP, 4, "t1_amp1");
      expect_at(63, S_AMP, 252, "t1_amp63");
      expect_at(63, S_BUSY, 1, "t1_busy63");
      expect_at(64, S_AMP, 255, "t1_amp_full");
      expect_at(64, S_BUSY, 0, "t1_run");
      tick(64);
      n_checks = n_checks + 1;
      if (amp_scale !== 8'd255) begin
         n_fail = n_fail + 1;
         $display("FAIL t1_direct_amp got=%0d expected=255", amp_scale);
      end
      n_checks = n_checks + 1;
      if (busy !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL t1_direct_busy got=%0d expected=0", busy);
      end

      // 2: warning ceiling and return to full scale
      warning = 1'b1;
      expect_at(31, S_AMP, 131, "t2_warn31");
      expect_at(32, S_AMP, 128, "t2_warn_clamp");
      expect_at(33, S_AMP, 128, "t2_warn_hold");
      expect_at(33, S_BUSY, 0, "t2_busy");
      tick(33);
      n_checks = n_checks + 1;
      if (amp_scale !== 8'd128) begin
         n_fail = n_fail + 1;
         $display("FAIL t2_direct_warn got=%0d expected=128", amp_scale);
      end
      warning = 1'b0;
      expect_at(31, S_AMP, 252, "t2_up31");
      expect_at(32, S_AMP, 255, "t2_up_full");
      tick(34);
      n_checks = n_checks + 1;
      if (amp_scale !== 8'd255) begin
         n_fail = n_fail + 1;
         $display("FAIL t2_direct_full got=%0d expected=255", amp_scale);
      end

      // 3: single fault pulse, full recovery
      force_reset = 1'b1;
      expect_at(1, S_FC, 1, "t3_fc");
      expect_at(1, S_AMP, 251, "t3_amp_dn");
      expect_at(1, S_BUSY, 1, "t3_busy");
      expect_at(63, S_AMP, 3, "t3_amp63");
      expect_at(63, S_MUTE, 0, "t3_mute63");
      expect_at(64, S_AMP, 0, "t3_amp0");
      expect_at(64, S_MUTE, 1, "t3_muted");
      expect_at(64, S_SRST, 0, "t3_srst_first");
      expect_at(79, S_SRST, 0, "t3_srst_last");
      expect_at(80, S_SRST, 1, "t3_srst_rel");
      expect_at(143, S_MUTE, 1, "t3_holdoff_end");
      expect_at(144, S_MUTE, 0, "t3_rampup_unmute");
      expect_at(144, S_AMP, 0, "t3_rampup_amp0");
      expect_at(145, S_AMP, 4, "t3_rampup_amp1");
      expect_at(207, S_BUSY, 1, "t3_busy207");
      expect_at(208, S_AMP, 255, "t3_full");
      expect_at(208, S_BUSY, 0, "t3_run");
      tick(1);
      force_reset = 1'b0;
      tick(209);

      // 5: fault held through RECOVER stalls there without recounting
      force_reset = 1'b1;
      expect_at(1, S_FC, 2, "t5_fc");
      expect_at(144, S_MUTE, 1, "t5_stall_mute");
      expect_at(150, S_MUTE, 1, "t5_stall_mute2");
      expect_at(150, S_FC, 2, "t5_no_recount");
      expect_at(150, S_AMP, 0, "t5_stall_amp");
      expect_at(151, S_MUTE, 0, "t5_release");
      expect_at(151, S_FC, 2, "t5_fc_after");
      expect_at(152, S_AMP, 4, "t5_rampup");
      expect_at(215, S_AMP, 255, "t5_full");
      expect_at(215, S_BUSY, 0, "t5_run");
      tick(150);
      force_reset = 1'b0;
      tick(67);

      // clear_lockout outside LOCKOUT has no effect
      clear_lockout = 1'b1;
      expect_at(2, S_FC, 2, "clr_ignored_fc");
      expect_at(2, S_BUSY, 0, "clr_ignored_busy");
      tick(1);
      clear_lockout = 1'b0;
      tick(2);
      n_checks = n_checks + 1;
      if (fault_count !== 4'd2) begin
         n_fail = n_fail + 1;
         $display("FAIL clr_direct_fc got=%0d expected=2", fault_count);
      end
      n_checks = n_checks + 1;
      if (busy !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL clr_direct_busy got=%0d expected=0", busy);
      end

      // 4: third fault locks out; clear wins over simultaneous fault
      force_reset = 1'b1;
      expect_at(1, S_FC, 3, "t4_fc3");
      expect_at(1, S_LOCK, 1, "t4_lock");
      expect_at(1, S_AMP, 251, "t4_amp_dn");
      expect_at(1, S_SRST, 1, "t4_srst");
      expect_at(63, S_MUTE, 0, "t4_mute63");
      expect_at(64, S_AMP, 0, "t4_amp0");
      expect_at(64, S_MUTE, 1, "t4_muted");
      expect_at(64, S_SRST, 1, "t4_srst64");
      expect_at(72, S_FC, 3, "t4_lock_nocount");
      expect_at(80, S_LOCK, 1, "t4_lock80");
      expect_at(81, S_FC, 0, "t4_clear_fc");
      expect_at(81, S_LOCK, 0, "t4_unlock");
      expect_at(81, S_SRST, 0, "t4_srst_low");
      expect_at(96, S_SRST, 0, "t4_srst_last");
      expect_at(97, S_SRST, 1, "t4_srst_rel");
      expect_at(160, S_MUTE, 1, "t4_holdoff");
      expect_at(161, S_MUTE, 0, "t4_rampup");
      expect_at(225, S_AMP, 255, "t4_full");
      expect_at(225, S_BUSY, 0, "t4_run");
      tick(1);
      force_reset = 1'b0;
      tick(69);
      force_reset = 1'b1;
      tick(1);
      force_reset = 1'b0;
      tick(9);
      force_reset = 1'b1;
      clear_lockout = 1'b1;
      tick(1);
      force_reset = 1'b0;
      clear_lockout = 1'b0;
      tick(147);
      n_checks = n_checks + 1;
      if (busy !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL t4_direct_busy got=%0d expected=0", busy);
      end
      n_checks = n_checks + 1;
      if (fault_count !== 4'd0) begin
         n_fail = n_fail + 1;
         $display("FAIL t4_direct_fc got=%0d expected=0", fault_count);
      end

      // 6: async reset in HOLD_RESET, then fault during RAMP_UP
      force_reset = 1'b1;
      expect_at(1, S_FC, 1, "t6_fc1");
      expect_at(69, S_SRST, 0, "t6_in_hold");
      tick(1);
      force_reset = 1'b0;
      tick(69);
      rstn = 1'b0;
      expect_at(0, S_AMP, 0, "t6_rst_amp");
      expect_at(0, S_MUTE, 1, "t6_rst_mute");
      expect_at(0, S_SRST, 0, "t6_rst_srst");
      expect_at(0, S_BUSY, 1, "t6_rst_busy");
      expect_at(0, S_FC, 0, "t6_rst_fc");
`ifdef FAULT_TIMESTAMP_EN
      expect_at(0, S_LAST, 0, "t6_rst_last");
      expect_at(0, S_FIRST, 0, "t6_rst_first");
`endif
      tick(2);
      rstn = 1'b1;
      expect_at(0, S_SRST, 0, "t6_srst_low");
      expect_at(1, S_SRST, 1, "t6_srst_high");
      expect_at(1, S_AMP, 4, "t6_amp1");
`ifdef FAULT_TIMESTAMP_EN
      expect_at(3, S_LAST, 0, "t6_last_pre");
      expect_at(4, S_LAST, 3, "t6_last_cap");
      expect_at(4, S_FIRST, 3, "t6_first_cap");
`endif
      expect_at(4, S_FC, 1, "t6_rampup_fault");
      expect_at(4, S_AMP, 8, "t6_amp_from_cur");
      expect_at(6, S_AMP, 0, "t6_amp0");
      expect_at(6, S_MUTE, 1, "t6_muted");
      expect_at(6, S_SRST, 0, "t6_hold");
      tick(3);
      force_reset = 1'b1;
      tick(1);
      force_reset = 1'b0;
      tick(4);

      // drain scoreboard
      for (int k = 0; k < 10 && sb.size() != 0; k++) tick(1);
      while (sb.size() != 0) begin
         n_checks = n_checks + 1;
         n_fail = n_fail + 1;
         $display("FAIL %s never checked due=%0d", sb[0].name, sb[0].cyc);
         sb.delete(0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
